// File: rtl/maze_mem_arbiter.sv
// Serialises host and rat accesses onto the single-port maze RAM.
// Round-robin between the two requesters; h_lock keeps the rat out while it is high.
module maze_mem_arbiter #(
  parameter int N = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           h_req,
  input  logic           h_wr,
  input  logic [N-1:0]   h_x,
  input  logic [N-1:0]   h_y,
  input  logic           h_din,
  input  logic           h_lock,
  output logic           h_ack,
  output logic           h_dout,
  input  logic           r_req,
  input  logic [N-1:0]   r_x,
  input  logic [N-1:0]   r_y,
  output logic           r_ack,
  output logic           r_dout,
  output logic [2*N-1:0] m_addr,
  output logic           m_rd,
  output logic           m_wr,
  output logic           m_din,
  input  logic           m_dout,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;   // 1 = rat owns the current access
  logic           last_q, last_d;     // 1 = rat received the most recent grant
  logic           wr_q, wr_d;
  logic [2*N-1:0] addr_q, addr_d;
  logic           din_q, din_d;
  logic           h_dout_q, h_dout_d;
  logic           r_dout_q, r_dout_d;
  logic           r_elig, grant_rat;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    din_d    = din_q;
    h_dout_d = h_dout_q;
    r_dout_d = r_dout_q;
    m_rd     = 1'b0;
    m_wr     = 1'b0;
    h_ack    = 1'b0;
    r_ack    = 1'b0;
    r_elig   = r_req & ~h_lock;
    // On a tie the rat wins only if the host had the previous grant.
    grant_rat = r_elig & (~h_req | ~last_q);

    case (state_q)
      IDLE: begin
        if (h_req || r_elig) begin
          owner_d = grant_rat;
          last_d  = grant_rat;
          addr_d  = grant_rat ? {r_y, r_x} : {h_y, h_x};
          din_d   = grant_rat ? 1'b0 : h_din;
          wr_d    = grant_rat ? 1'b0 : h_wr;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        m_rd    = ~wr_q;
        m_wr    = wr_q;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!wr_q) begin
          if (owner_q) r_dout_d = m_dout;
          else         h_dout_d = m_dout;
        end
        state_d = ACK;
      end
      ACK: begin
        h_ack   = ~owner_q;
        r_ack   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= 1'b0;
      h_dout_q <= 1'b0;
      r_dout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      h_dout_q <= h_dout_d;
      r_dout_q <= r_dout_d;
    end
  end

  assign m_addr = addr_q;
  assign m_din  = din_q;
  assign h_dout = h_dout_q;
  assign r_dout = r_dout_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: transaction-level reference model plus directed scenarios.
module tb_maze_mem_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       h_req = 1'b0, h_wr = 1'b0, h_din = 1'b0, h_lock = 1'b0;
  logic [3:0] h_x = '0, h_y = '0, r_x = '0, r_y = '0;
  logic       r_req = 1'b0;
  logic       h_ack, h_dout, r_ack, r_dout, m_rd, m_wr, m_din, busy;
  logic [7:0] m_addr;
  logic       m_dout = 1'b0;

  int total = 0;
  int bad   = 0;

  maze_mem_arbiter #(.N(4)) dut (
    .CLK(CLK), .RST(RST),
    .h_req(h_req), .h_wr(h_wr), .h_x(h_x), .h_y(h_y), .h_din(h_din), .h_lock(h_lock),
    .h_ack(h_ack), .h_dout(h_dout),
    .r_req(r_req), .r_x(r_x), .r_y(r_y), .r_ack(r_ack), .r_dout(r_dout),
    .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_din(m_din), .m_dout(m_dout),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Maze RAM: synchronous single port, read data the cycle after m_rd.
  logic ram [0:255];
  initial for (int i = 0; i < 256; i++) ram[i] = 1'b0;
  always @(posedge CLK) begin
    if (m_wr) ram[m_addr] <= m_din;
    if (m_rd) m_dout <= ram[m_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase counts cycles since grant (0 = idle); shadow memory holds maze contents.
  int       phase = 0;
  bit       own_rat = 0, acc_wr = 0, acc_din = 0, last_rat = 1, hd = 0, rd = 0, cap = 0;
  bit [7:0] acc_addr = 0;
  bit       shadow [256];

  initial forever begin
    @(posedge CLK);
    if (RST) begin
      phase = 0; own_rat = 0; acc_wr = 0; acc_din = 0; acc_addr = 0;
      last_rat = 1; hd = 0; rd = 0;
    end else if (phase == 0) begin
      bit he, re;
      he = h_req;
      re = r_req && !h_lock;
      if (he || re) begin
        own_rat  = (he && re) ? !last_rat : re;
        last_rat = own_rat;
        acc_addr = own_rat ? {r_y, r_x} : {h_y, h_x};
        acc_din  = own_rat ? 1'b0 : h_din;
        acc_wr   = own_rat ? 1'b0 : h_wr;
        phase    = 1;
      end
    end else if (phase == 1) begin
      if (acc_wr) shadow[acc_addr] = acc_din;
      else        cap = shadow[acc_addr];
      phase = 2;
    end else if (phase == 2) begin
      if (!acc_wr) begin
        if (own_rat) rd = cap;
        else         hd = cap;
      end
      phase = 3;
    end else begin
      phase = 0;
    end
  end

  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      chk("busy",   32'(busy),   32'(phase != 0));
      chk("m_rd",   32'(m_rd),   32'(phase == 1 && !acc_wr));
      chk("m_wr",   32'(m_wr),   32'(phase == 1 && acc_wr));
      chk("m_addr", 32'(m_addr), 32'(acc_addr));
      chk("m_din",  32'(m_din),  32'(acc_din));
      chk("h_ack",  32'(h_ack),  32'(phase == 3 && !own_rat));
      chk("r_ack",  32'(r_ack),  32'(phase == 3 && own_rat));
      chk("h_dout", 32'(h_dout), 32'(hd));
      chk("r_dout", 32'(r_dout), 32'(rd));
    end
  end

  // Wait (bounded) for the requester's ack; cycle 1 is the cycle after the request cycle.
  task automatic wait_ack(input bit rat, input int maxc, output int ack_cyc,
                          output int nstb, output logic [7:0] saddr, output int other);
    ack_cyc = -1; nstb = 0; saddr = '0; other = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge CLK); #4;
      if (m_rd || m_wr) begin nstb++; saddr = m_addr; end
      if (rat ? h_ack : r_ack) other++;
      if (rat ? r_ack : h_ack) begin
        ack_cyc = c;
        if (rat) r_req = 1'b0; else h_req = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_op(input bit rat, input bit wr, input logic [3:0] x, input logic [3:0] y,
                        input bit din, output int ack_cyc, output int nstb,
                        output logic [7:0] saddr, output int other);
    @(posedge CLK); #2;
    if (rat) begin r_req = 1'b1; r_x = x; r_y = y; end
    else begin h_req = 1'b1; h_wr = wr; h_x = x; h_y = y; h_din = din; end
    wait_ack(rat, 10, ack_cyc, nstb, saddr, other);
  endtask

  int         ac, ns, oth, n, nrd, nack;
  logic [7:0] sa;
  int         seq [8];

  initial begin
    repeat (2) @(posedge CLK);
    #4;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset m_addr", 32'(m_addr), 32'd0);
    chk("reset douts", 32'({h_dout, r_dout}), 32'd0);
    RST = 1'b0;

    // Host writes 1 to (3,5)
    run_op(0, 1, 4'd3, 4'd5, 1, ac, ns, sa, oth);
    chk("hw ack latency", 32'(ac), 32'd3);
    chk("hw strobe count", 32'(ns), 32'd1);
    chk("hw strobe addr", 32'(sa), 32'h53);
    chk("hw no r_ack", 32'(oth), 32'd0);

    // Rat reads the wall just written
    run_op(1, 0, 4'd3, 4'd5, 0, ac, ns, sa, oth);
    chk("rr ack latency", 32'(ac), 32'd3);
    chk("rr strobe addr", 32'(sa), 32'h53);
    chk("rr r_dout", 32'(r_dout), 32'd1);
    chk("rr h_dout held", 32'(h_dout), 32'd0);

    // Simultaneous requests from reset alternate host, rat, ...
    @(posedge CLK); #2; RST = 1'b1;
    @(posedge CLK); #2; RST = 1'b0;
    h_req = 1'b1; h_wr = 1'b0; h_x = 4'd0; h_y = 4'd0;
    r_req = 1'b1; r_x = 4'd1; r_y = 4'd0;
    n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      @(posedge CLK); #4;
      if (h_ack) begin seq[n] = 0; n++; end
      if (r_ack) begin seq[n] = 1; n++; end
      if (n >= 8) begin h_req = 1'b0; r_req = 1'b0; end
    end
    h_req = 1'b0; r_req = 1'b0;
    chk("rr grant count", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) chk("rr grant order", 32'(seq[i]), 32'(i % 2));

    // Lock holds off the rat, then releases it
    @(posedge CLK); #2;
    h_lock = 1'b1; r_req = 1'b1; r_x = 4'd3; r_y = 4'd5;
    nrd = 0; nack = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #4;
      if (m_rd) nrd++;
      if (r_ack) nack++;
    end
    chk("lock no m_rd", 32'(nrd), 32'd0);
    chk("lock no r_ack", 32'(nack), 32'd0);
    @(posedge CLK); #2; h_lock = 1'b0;
    wait_ack(1, 10, ac, ns, sa, oth);
    chk("unlock ack latency", 32'(ac), 32'd3);
    chk("unlock r_dout", 32'(r_dout), 32'd1);

    // Reset during CAPTURE of a rat read drops it
    @(posedge CLK); #2; r_req = 1'b1; r_x = 4'd3; r_y = 4'd5;
    @(posedge CLK); #4;
    @(posedge CLK); #4;
    RST = 1'b1; r_req = 1'b0;
    @(posedge CLK); #4;
    chk("rst no r_ack", 32'(r_ack), 32'd0);
    chk("rst r_dout", 32'(r_dout), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    RST = 1'b0;
    run_op(1, 0, 4'd3, 4'd5, 0, ac, ns, sa, oth);
    chk("reissue ack latency", 32'(ac), 32'd3);
    chk("reissue r_dout", 32'(r_dout), 32'd1);

    // Corner cell (15,15) and host read-back
    run_op(0, 0, 4'd3, 4'd5, 0, ac, ns, sa, oth);
    chk("hr wall h_dout", 32'(h_dout), 32'd1);
    run_op(0, 1, 4'd15, 4'd15, 0, ac, ns, sa, oth);
    chk("hw corner addr", 32'(sa), 32'hFF);
    chk("hw h_dout held", 32'(h_dout), 32'd1);
    run_op(0, 0, 4'd15, 4'd15, 0, ac, ns, sa, oth);
    chk("hr corner addr", 32'(sa), 32'hFF);
    chk("hr corner h_dout", 32'(h_dout), 32'd0);
    run_op(1, 0, 4'd3, 4'd5, 0, ac, ns, sa, oth);
    chk("rat wall r_dout", 32'(r_dout), 32'd1);
    chk("rat leaves h_dout", 32'(h_dout), 32'd0);

    repeat (3) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/maze_mem_arbiter.md
# maze_mem_arbiter

Shares the single-port synchronous maze memory (2^(2N) one-bit cells, one cell per (X,Y)) between two requesters: the host loader, which writes or reads maze cells, and the rat solver, which only reads cells while exploring. A four-state sequencer serialises accesses, arbitrates round-robin with a host lock override, and returns read data with a registered acknowledge. Sits between the rat top level / host interface and the maze RAM.

## Interface
- N, 4, coordinate width; memory address width is 2N, laid out {Y, X}
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- h_req  input  1  host request, held high until h_ack
- h_wr  input  1  host access type: 1 write, 0 read; sampled with h_req
- h_x, h_y  input  N each  host cell coordinates
- h_din  input  1  host write data
- h_lock  input  1  host lock; while high the rat is never granted
- h_ack  output  1  one-cycle host completion pulse
- h_dout  output  1  host read data, valid from h_ack onward
- r_req  input  1  rat read request, held high until r_ack
- r_x, r_y  input  N each  rat cell coordinates
- r_ack  output  1  one-cycle rat completion pulse
- r_dout  output  1  rat read data (1 = wall), valid from r_ack onward
- m_addr  output  2N  memory address, registered
- m_rd, m_wr  output  1 each  memory strobes, mutually exclusive
- m_din  output  1  memory write data, registered
- m_dout  input  1  memory read data, valid the cycle after the m_rd cycle
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, CAPTURE, ACK; unconditional sequence ACCESS -> CAPTURE -> ACK -> IDLE.
- IDLE: evaluate requests. Eligible rat = r_req & ~h_lock. Only one eligible -> grant it. Both -> grant the one not in last_grant; then last_grant <= granted. On grant: latch owner, m_addr <= {y,x}, m_din <= h_din (host) or 0, latch write flag = h_wr (host) or 0 (rat); go ACCESS.
- ACCESS: m_rd = ~wr_flag, m_wr = wr_flag, both for exactly this cycle.
- CAPTURE: on read, owner's dout register <= m_dout at end of cycle; on write, dout registers unchanged.
- ACK: owner's ack = 1 for this cycle only; return to IDLE.
- dout registers hold their value until overwritten by the same owner's next read.
- Host read returns memory contents; host write returns h_ack with h_dout unchanged.
- h_lock is sampled only in IDLE; asserting it mid-transaction does not abort a granted rat access.
- Requester must deassert req in the cycle after ack; a req still high in IDLE is a new request.
- Request changes in non-IDLE states are ignored; addresses and data are latched only at grant.

## Timing
- Reset values: state IDLE, h_ack = r_ack = 0, m_rd = m_wr = 0, m_addr = 0, m_din = 0, h_dout = r_dout = 0, busy = 0, last_grant = rat (host wins the first tie).
- Latency: request seen in IDLE at cycle t -> strobe at t+1 -> capture at t+2 -> ack at t+3; back in IDLE at t+4. Peak throughput is one access per 4 cycles.
- Under continuous simultaneous requests, grants strictly alternate host, rat, host, ...
- RST asserted in any state: next cycle matches reset values exactly, the in-flight access is dropped with no ack, and no strobe is issued after the reset edge.
- Strobes and acks are never asserted together; at most one ack per transaction.

## Test plan
- Reset, then host writes 1 to (3,5) -> m_wr high exactly one cycle with m_addr = 0x53, m_din = 1; h_ack pulses 3 cycles after the h_req cycle; r_ack stays 0.
- Rat reads (3,5) with memory holding 1 -> m_rd one cycle with m_addr = 0x53; r_dout = 1 when r_ack pulses at t+3; h_dout unchanged.
- h_req and r_req held high together from reset for 4 transactions each -> grants host, rat, host, rat, ...; each ack one cycle; no overlapping strobes.
- h_lock = 1 with r_req held high for 20 cycles -> no r_ack and no m_rd; h_lock drops -> r_ack arrives 3 cycles after the first IDLE cycle with h_lock low.
- RST in the CAPTURE cycle of a rat read -> no r_ack; r_dout = 0 and busy = 0 the next cycle; re-issued request completes normally.
- Host read of (15,15) after writing 0 -> m_addr = 0xFF, h_dout = 0; a following rat read of a wall cell leaves h_dout at 0.
